// File: rtl/rv32i_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_core_if
//  Description : Internal bus between the rv32i_core datapath and its unified
//                byte memory. It carries one instruction fetch port and one
//                data load/store port.
//                  iaddr  - fetch byte address (the current pc)
//                  idata  - 4 bytes at iaddr, little-endian
//                  daddr  - load/store byte address
//                  drdata - 4 bytes at daddr, little-endian
//                  dwdata - store data, low bytes first
//                  dwe    - store enable for this cycle
//                  dsize  - store size: 0 = byte, 1 = half, 2 = word
//                The master modport is the datapath side and the slave
//                modport is the memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface rv32i_core_if;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic [31:0] daddr;
   logic [31:0] drdata;
   logic [31:0] dwdata;
   logic        dwe;
   logic [1:0]  dsize;

   modport master (output iaddr, daddr, dwdata, dwe, dsize,
                   input  idata, drdata);
   modport slave  (input  iaddr, daddr, dwdata, dwe, dsize,
                   output idata, drdata);
endinterface
`default_nettype wire

// File: rtl/rv32i_core.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_core (with rv32i_core_mem)
//  Description : Single-cycle RV32I + Zicsr machine-mode core with an internal
//                unified little-endian byte memory. Each posedge outside reset
//                retires one instruction. The rd, memory, CSR and pc writes
//                commit together on that edge.
//  Ports       : clk - single clock, all state updates on posedge
//                rst - synchronous active-high reset
//                      (pc = RESET_PC, rs and csr cleared, memory kept)
//  Parameters  : MEM_DEPTH - bytes of memory; address = addr % MEM_DEPTH
//                RESET_PC  - pc loaded on reset
//  Options     : CORE_TRACE_EN - when defined, each retired instruction
//                prints "pc instr rd_idx rd_val" (simulation only)
//  Revision    : 1.0  initial release
// ============================================================================

// Byte memory: combinational 4-byte reads on both ports, stores on posedge.
module rv32i_core_mem #(
   parameter int MEM_DEPTH = 65536
) (
   input  wire logic     clk,
   rv32i_core_if.slave   bus
);
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [7:0] m [0:MEM_DEPTH-1];

   function automatic logic [AW-1:0] wrap(input logic [31:0] a);
      wrap = AW'(a % 32'(MEM_DEPTH));
   endfunction

   assign bus.idata  = {m[wrap(bus.iaddr + 32'd3)], m[wrap(bus.iaddr + 32'd2)],
                        m[wrap(bus.iaddr + 32'd1)], m[wrap(bus.iaddr)]};
   assign bus.drdata = {m[wrap(bus.daddr + 32'd3)], m[wrap(bus.daddr + 32'd2)],
                        m[wrap(bus.daddr + 32'd1)], m[wrap(bus.daddr)]};

   always_ff @(posedge clk) begin
      if (bus.dwe) begin
         m[wrap(bus.daddr)] <= bus.dwdata[7:0];
         if (bus.dsize != 2'd0)
            m[wrap(bus.daddr + 32'd1)] <= bus.dwdata[15:8];
         if (bus.dsize == 2'd2) begin
            m[wrap(bus.daddr + 32'd2)] <= bus.dwdata[23:16];
            m[wrap(bus.daddr + 32'd3)] <= bus.dwdata[31:24];
         end
      end
   end
endmodule

module rv32i_core #(
   parameter int          MEM_DEPTH = 65536,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input wire logic clk,
   input wire logic rst
);
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   localparam logic [11:0] CSR_MTVEC  = 12'h305;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;

   rv32i_core_if bus ();

   rv32i_core_mem #(.MEM_DEPTH(MEM_DEPTH)) memory (
      .clk (clk),
      .bus (bus.slave)
   );

   logic [31:0] pc;
   logic [31:0] rs  [0:31];
   logic [31:0] csr [0:4095];

   // ---------------- decode ----------------
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rd, r1, r2;
   logic [2:0]  f3;
   logic [11:0] csr_addr;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] a, b;

   assign instr    = bus.idata;
   assign opcode   = instr[6:0];
   assign rd       = instr[11:7];
   assign f3       = instr[14:12];
   assign r1       = instr[19:15];
   assign r2       = instr[24:20];
   assign csr_addr = instr[31:20];
   assign imm_i    = {{20{instr[31]}}, instr[31:20]};
   assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u    = {instr[31:12], 12'b0};
   assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign a        = (r1 == 5'd0) ? 32'd0 : rs[r1];
   assign b        = (r2 == 5'd0) ? 32'd0 : rs[r2];

   // ---------------- ALU ----------------
   logic [31:0] op_b, alu_res;
   logic        alt;
   logic [4:0]  shamt;

   always_comb begin
      op_b = (opcode == OP_REG) ? b : imm_i;
      // instr[30] selects SUB only for register ops; SRA/SRAI in both forms.
      if (opcode == OP_REG)
         alt = instr[30] & ((f3 == 3'b000) | (f3 == 3'b101));
      else
         alt = instr[30] & (f3 == 3'b101);
      shamt = op_b[4:0];
      case (f3)
         3'b000:  alu_res = alt ? (a - op_b) : (a + op_b);
         3'b001:  alu_res = a << shamt;
         3'b010:  alu_res = {31'd0, $signed(a) < $signed(op_b)};
         3'b011:  alu_res = {31'd0, a < op_b};
         3'b100:  alu_res = a ^ op_b;
         3'b101:  alu_res = alt ? 32'($signed(a) >>> shamt) : (a >> shamt);
         3'b110:  alu_res = a | op_b;
         default: alu_res = a & op_b;
      endcase
   end

   // ---------------- branch condition ----------------
   logic take;

   always_comb begin
      case (f3)
         3'b000:  take = (a == b);
         3'b001:  take = (a != b);
         3'b100:  take = ($signed(a) < $signed(b));
         3'b101:  take = ($signed(a) >= $signed(b));
         3'b110:  take = (a < b);
         3'b111:  take = (a >= b);
         default: take = 1'b0;
      endcase
   end

   // ---------------- execute / commit control ----------------
   logic [31:0] next_pc, rd_val, daddr, csr_old, csr_src, csr_wval, trap_cause;
   logic        rd_we, store_en, csr_we, trap;
   logic [1:0]  store_size;

   assign csr_old = csr[csr_addr];
   assign csr_src = f3[2] ? {27'd0, r1} : a;

   always_comb begin
      next_pc    = pc + 32'd4;
      rd_we      = 1'b0;
      rd_val     = 32'd0;
      daddr      = a + imm_i;
      store_en   = 1'b0;
      store_size = 2'd0;
      csr_we     = 1'b0;
      csr_wval   = 32'd0;
      trap       = 1'b0;
      trap_cause = 32'd0;
      case (opcode)
         OP_LUI: begin
            rd_we  = 1'b1;
            rd_val = imm_u;
         end
         OP_AUIPC: begin
            rd_we  = 1'b1;
            rd_val = pc + imm_u;
         end
         OP_JAL: begin
            rd_we   = 1'b1;
            rd_val  = pc + 32'd4;
            next_pc = pc + imm_j;
         end
         OP_JALR: begin
            rd_we   = 1'b1;
            rd_val  = pc + 32'd4;
            next_pc = (a + imm_i) & ~32'd1;
         end
         OP_BRANCH: begin
            if (take)
               next_pc = pc + imm_b;
         end
         OP_LOAD: begin
            rd_we = 1'b1;
            case (f3)
               3'b000:  rd_val = {{24{bus.drdata[7]}}, bus.drdata[7:0]};
               3'b001:  rd_val = {{16{bus.drdata[15]}}, bus.drdata[15:0]};
               3'b010:  rd_val = bus.drdata;
               3'b100:  rd_val = {24'd0, bus.drdata[7:0]};
               3'b101:  rd_val = {16'd0, bus.drdata[15:0]};
               default: rd_we  = 1'b0;
            endcase
         end
         OP_STORE: begin
            daddr      = a + imm_s;
            store_en   = (f3 <= 3'd2);
            store_size = f3[1:0];
         end
         OP_IMM, OP_REG: begin
            rd_we  = 1'b1;
            rd_val = alu_res;
         end
         OP_SYSTEM: begin
            if (f3 == 3'b000) begin
               case (csr_addr)
                  12'h000: begin
                     trap       = 1'b1;
                     trap_cause = 32'd11;
                     next_pc    = csr[CSR_MTVEC] & ~32'd3;
                  end
                  12'h001: begin
                     trap       = 1'b1;
                     trap_cause = 32'd3;
                     next_pc    = csr[CSR_MTVEC] & ~32'd3;
                  end
                  12'h302: next_pc = csr[CSR_MEPC];
                  default: ;
               endcase
            end else if (f3 != 3'b100) begin
               rd_we  = 1'b1;
               rd_val = csr_old;
               case (f3[1:0])
                  2'b01: begin
                     csr_we   = 1'b1;
                     csr_wval = csr_src;
                  end
                  2'b10: begin
                     csr_we   = (r1 != 5'd0);
                     csr_wval = csr_old | csr_src;
                  end
                  default: begin
                     csr_we   = (r1 != 5'd0);
                     csr_wval = csr_old & ~csr_src;
                  end
               endcase
            end
         end
         default: ;
      endcase
   end

   assign bus.iaddr  = pc;
   assign bus.daddr  = daddr;
   assign bus.dwdata = b;
   assign bus.dsize  = store_size;
   // Reset wins over a store retiring in the same cycle.
   assign bus.dwe    = store_en & ~rst;

   // ---------------- architectural state ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++)
            rs[i] <= 32'd0;
         for (int j = 0; j < 4096; j++)
            csr[j] <= 32'd0;
      end else begin
         pc <= next_pc;
         if (rd_we && (rd != 5'd0))
            rs[rd] <= rd_val;
         if (csr_we)
            csr[csr_addr] <= csr_wval;
         if (trap) begin
            csr[CSR_MEPC]   <= pc;
            csr[CSR_MCAUSE] <= trap_cause;
         end
      end
   end

`ifdef CORE_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst)
         $display("%h %h %0d %h", pc, instr,
                  (rd_we && rd != 5'd0) ? rd : 5'd0,
                  (rd_we && rd != 5'd0) ? rd_val : 32'd0);
   end
`else
   // Trace output compiled out; the datapath is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32i_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_core
//  Description : Directed bench for rv32i_core. Small hand-assembled programs
//                are poked into dut.memory.m while the core is held in reset,
//                then run for a fixed number of cycles before the register,
//                CSR, pc and memory contents are compared against
//                hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32i_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests  = 0;
   int   failed = 0;

   rv32i_core dut (.clk(clk), .rst(rst));

   always #5 clk = ~clk;

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   // ---------------- helpers ----------------
   task automatic put(input logic [15:0] addr, input logic [31:0] w);
      dut.memory.m[addr]         = w[7:0];
      dut.memory.m[addr + 16'd1] = w[15:8];
      dut.memory.m[addr + 16'd2] = w[23:16];
      dut.memory.m[addr + 16'd3] = w[31:24];
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Hold reset across an edge and clear the low program/data area.
   task automatic begin_prog();
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16'h400; i++)
         dut.memory.m[16'(i)] = 8'h00;
   endtask

   task automatic start();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset state and first retirements ----
      begin_prog();
      put(16'h0000, enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'h13));      // addi x3,x0,1
      start();
      check("reset_pc", dut.pc, 32'h0);
      check("reset_x3", dut.rs[3], 32'h0);
      check("reset_mtvec", dut.csr[12'h305], 32'h0);
      step(2);
      check("first_pc", dut.pc, 32'h8);
      check("first_x3", dut.rs[3], 32'h1);

      // ---- shifts / compares / sub ----
      begin_prog();
      put(16'h0000, enc_u(20'h80000, 5'd1, 7'h37));                // lui x1,0x80000
      put(16'h0004, enc_i(12'd4, 5'd0, 3'b000, 5'd7, 7'h13));      // addi x7,x0,4
      put(16'h0008, enc_r(7'h20, 5'd0, 5'd1, 3'b101, 5'd2));       // sra x2,x1,x0
      put(16'h000C, enc_i(12'h404, 5'd1, 3'b101, 5'd4, 7'h13));    // srai x4,x1,4
      put(16'h0010, enc_i(12'h004, 5'd1, 3'b101, 5'd5, 7'h13));    // srli x5,x1,4
      put(16'h0014, enc_r(7'h00, 5'd7, 5'd1, 3'b101, 5'd6));       // srl x6,x1,x7
      put(16'h0018, enc_r(7'h00, 5'd7, 5'd1, 3'b010, 5'd8));       // slt x8,x1,x7
      put(16'h001C, enc_r(7'h00, 5'd7, 5'd1, 3'b011, 5'd9));       // sltu x9,x1,x7
      put(16'h0020, enc_r(7'h20, 5'd1, 5'd7, 3'b000, 5'd10));      // sub x10,x7,x1
      start();
      step(9);
      check("sra_by_x0", dut.rs[2], 32'h80000000);
      check("srai_4", dut.rs[4], 32'hF8000000);
      check("srli_4", dut.rs[5], 32'h08000000);
      check("srl_reg", dut.rs[6], 32'h08000000);
      check("slt_signed", dut.rs[8], 32'h1);
      check("sltu_unsigned", dut.rs[9], 32'h0);
      check("sub_wrap", dut.rs[10], 32'h80000004);

      // ---- loads and stores ----
      begin_prog();
      put(16'h0000, enc_u(20'h12345, 5'd1, 7'h37));                // lui x1,0x12345
      put(16'h0004, enc_i(12'h678, 5'd1, 3'b000, 5'd1, 7'h13));    // addi x1,x1,0x678
      put(16'h0008, enc_i(12'h100, 5'd0, 3'b000, 5'd2, 7'h13));    // addi x2,x0,0x100
      put(16'h000C, enc_s(12'd0, 5'd1, 5'd2, 3'b010));             // sw x1,0(x2)
      put(16'h0010, enc_i(12'd1, 5'd2, 3'b000, 5'd3, 7'h03));      // lb x3,1(x2)
      put(16'h0014, enc_i(12'd2, 5'd2, 3'b101, 5'd4, 7'h03));      // lhu x4,2(x2)
      put(16'h0018, enc_i(12'h0AB, 5'd0, 3'b000, 5'd5, 7'h13));    // addi x5,x0,0xAB
      put(16'h001C, enc_s(12'd3, 5'd5, 5'd2, 3'b000));             // sb x5,3(x2)
      put(16'h0020, enc_i(12'd0, 5'd2, 3'b010, 5'd6, 7'h03));      // lw x6,0(x2)
      put(16'h0024, enc_i(12'd3, 5'd2, 3'b000, 5'd7, 7'h03));      // lb x7,3(x2)
      put(16'h0028, enc_i(12'd2, 5'd2, 3'b001, 5'd8, 7'h03));      // lh x8,2(x2)
      put(16'h002C, enc_i(12'd1, 5'd2, 3'b010, 5'd9, 7'h03));      // lw x9,1(x2)
      start();
      step(12);
      check("lb_0x101", dut.rs[3], 32'h00000056);
      check("lhu_0x102", dut.rs[4], 32'h00001234);
      check("lw_after_sb", dut.rs[6], 32'hAB345678);
      check("lb_sign", dut.rs[7], 32'hFFFFFFAB);
      check("lh_sign", dut.rs[8], 32'hFFFFAB34);
      check("lw_misaligned", dut.rs[9], 32'h00AB3456);
      check("mem_byte_0x103", {24'd0, dut.memory.m[16'h0103]}, 32'h000000AB);
      check("mem_byte_0x104", {24'd0, dut.memory.m[16'h0104]}, 32'h00000000);

      // ---- CSR access, ECALL and MRET ----
      begin_prog();
      put(16'h0000, enc_i(12'h200, 5'd0, 3'b000, 5'd1, 7'h13));    // addi x1,x0,0x200
      put(16'h0004, enc_i(12'h305, 5'd1, 3'b001, 5'd6, 7'h73));    // csrrw x6,mtvec,x1
      put(16'h0008, enc_i(12'h305, 5'd3, 3'b110, 5'd7, 7'h73));    // csrrsi x7,mtvec,3
      put(16'h000C, enc_j(21'h34, 5'd0));                          // jal x0,0x40
      put(16'h0040, 32'h00000073);                                 // ecall
      put(16'h0200, enc_i(12'h341, 5'd0, 3'b010, 5'd5, 7'h73));    // csrrs x5,mepc,x0
      put(16'h0204, 32'h30200073);                                 // mret
      start();
      step(4);
      check("csrrw_old", dut.rs[6], 32'h0);
      check("csrrsi_old", dut.rs[7], 32'h200);
      check("mtvec_set", dut.csr[12'h305], 32'h203);
      check("jal_target", dut.pc, 32'h40);
      step(1);
      check("ecall_pc", dut.pc, 32'h200);
      check("ecall_mepc", dut.csr[12'h341], 32'h40);
      check("ecall_mcause", dut.csr[12'h342], 32'd11);
      step(1);
      check("csrrs_read", dut.rs[5], 32'h40);
      check("csrrs_x0_nowrite", dut.csr[12'h341], 32'h40);
      step(1);
      check("mret_pc", dut.pc, 32'h40);

      // ---- x0 hardwired, then reset mid-run ----
      begin_prog();
      put(16'h0000, enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'h13));      // addi x0,x0,5
      put(16'h0004, enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'h13));      // addi x3,x0,1
      put(16'h0008, enc_j(21'h0, 5'd0));                           // jal x0,0
      start();
      step(6);
      check("x0_zero", dut.rs[0], 32'h0);
      check("loop_x3", dut.rs[3], 32'h1);
      check("loop_pc", dut.pc, 32'h8);
      rst = 1'b1;
      step(1);
      check("midrst_pc", dut.pc, 32'h0);
      check("midrst_x3", dut.rs[3], 32'h0);
      check("midrst_mem_kept", {24'd0, dut.memory.m[16'h0004]}, 32'h00000093);
      rst = 1'b0;
      step(2);
      check("after_rst_x3", dut.rs[3], 32'h1);

      // ---- self-checking sra program, gp == 1 on pass ----
      begin_prog();
      put(16'h0000, enc_u(20'h80000, 5'd1, 7'h37));                // lui x1,0x80000
      put(16'h0004, enc_i(12'h41F, 5'd1, 3'b101, 5'd2, 7'h13));    // srai x2,x1,31
      put(16'h0008, enc_i(12'hFFF, 5'd0, 3'b000, 5'd4, 7'h13));    // addi x4,x0,-1
      put(16'h000C, enc_b(13'd12, 5'd4, 5'd2, 3'b001));            // bne x2,x4,+12
      put(16'h0010, enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'h13));      // addi x3,x0,1
      put(16'h0014, enc_j(21'h0, 5'd0));                           // jal x0,0
      put(16'h0018, enc_i(12'd2, 5'd0, 3'b000, 5'd3, 7'h13));      // addi x3,x0,2
      put(16'h001C, enc_j(21'h0, 5'd0));                           // jal x0,0
      start();
      step(5000);
      check("sra_prog_gp", dut.rs[3], 32'h1);
      check("sra_prog_pc", dut.pc, 32'h14);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire
